i2c_codec_responder: RTL and testbench

I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

---
 rtl/i2c_codec_responder_pkg.sv | 49 ++++
 rtl/i2c_codec_responder_line_sync.sv | 53 +++++
 rtl/i2c_codec_responder.sv | 168 ++++++++++++++++
 tb/tb_i2c_codec_responder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_codec_responder_pkg.sv
// Shared types and constants for the I2C codec register responder.
package i2c_codec_responder_pkg;

    localparam int unsigned DATA_W     = 9;
    localparam int unsigned REG_ADDR_W = 7;
    localparam int unsigned RD_ADDR_W  = 4;
    localparam int unsigned BIT_CNT_W  = 4;
    localparam int unsigned RESET_REG  = 15;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_A,
        BYTE1,
        ACK_1,
        BYTE2,
        ACK_2,
        IGNORE
    } state_e;

    localparam logic [DATA_W-1:0] R0_DEFAULT = 9'h097;
    localparam logic [DATA_W-1:0] R1_DEFAULT = 9'h097;
    localparam logic [DATA_W-1:0] R2_DEFAULT = 9'h079;
    localparam logic [DATA_W-1:0] R3_DEFAULT = 9'h079;
    localparam logic [DATA_W-1:0] R4_DEFAULT = 9'h00A;
    localparam logic [DATA_W-1:0] R5_DEFAULT = 9'h008;
    localparam logic [DATA_W-1:0] R6_DEFAULT = 9'h09F;
    localparam logic [DATA_W-1:0] R7_DEFAULT = 9'h00A;
    localparam logic [DATA_W-1:0] R8_DEFAULT = 9'h000;
    localparam logic [DATA_W-1:0] R9_DEFAULT = 9'h000;

    // Power-on / soft-reset value of register idx
    function automatic logic [DATA_W-1:0] reg_default(input int unsigned idx);
        case (idx)
            0:       return R0_DEFAULT;
            1:       return R1_DEFAULT;
            2:       return R2_DEFAULT;
            3:       return R3_DEFAULT;
            4:       return R4_DEFAULT;
            5:       return R5_DEFAULT;
            6:       return R6_DEFAULT;
            7:       return R7_DEFAULT;
            8:       return R8_DEFAULT;
            9:       return R9_DEFAULT;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/i2c_codec_responder_line_sync.sv
// SCL/SDA synchronizers with START, STOP and SCL edge detection.
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_c,
    output logic scl_rise_c,
    output logic scl_fall_c,
    output logic start_c,
    output logic stop_c
);

    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_prev_q, scl_prev_d;
    logic       sda_prev_q, sda_prev_d;
    logic       scl_s;
    logic       sda_s;

    // Next values: shift raw lines through two stages, keep one cycle of history
    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_in};
        sda_sync_d = {sda_sync_q[0], sda_in};
        scl_prev_d = scl_sync_q[1];
        sda_prev_d = sda_sync_q[1];
    end

    // Synchronizer and history flops; idle bus level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_s      = scl_sync_q[1];
    assign sda_s      = sda_sync_q[1];
    assign sda_c      = sda_s;
    assign scl_rise_c = scl_s & ~scl_prev_q;
    assign scl_fall_c = ~scl_s & scl_prev_q;
    // SDA transitions are only bus conditions while SCL stays high across both samples
    assign start_c    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_c     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_codec_responder.sv
// Write-only I2C responder feeding a 9-bit codec register file.
module i2c_codec_responder
    import i2c_codec_responder_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h1A,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i2c_sclk,
    input  logic                  i2c_sdat_in,
    output logic                  i2c_sdat_oe,
    output logic                  wr_valid,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    input  logic [RD_ADDR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  busy
);

    localparam logic [7:0] ADDR_MATCH = {DEV_ADDR, 1'b0};

    logic sda_s, scl_rise_c, scl_fall_c, start_c, stop_c;

    state_e                state_q, state_d;
    logic [BIT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic                  data_hi_q, data_hi_d;
    logic                  oe_q, oe_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [DATA_W-1:0]     regs_d [NUM_REGS];
    logic                  byte_done_c, reg_ok_c, shifting_c;

    i2c_line_sync u_line_sync (
        .clk        (clk),
        .rst_n      (reset),
        .scl_in     (i2c_sclk),
        .sda_in     (i2c_sdat_in),
        .sda_c      (sda_s),
        .scl_rise_c (scl_rise_c),
        .scl_fall_c (scl_fall_c),
        .start_c    (start_c),
        .stop_c     (stop_c)
    );

    assign byte_done_c = (cnt_q == BIT_CNT_W'(8));
    assign reg_ok_c    = (32'(shift_q[7:1]) < NUM_REGS);
    assign shifting_c  = (state_q == ADDR) || (state_q == BYTE1) || (state_q == BYTE2);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: bus conditions override everything, otherwise advance on SCL falls
    always_comb begin
        state_d = state_q;
        if (start_c) begin
            state_d = ADDR;
        end else if (stop_c) begin
            state_d = IDLE;
        end else if (scl_fall_c) begin
            case (state_q)
                ADDR:    if (byte_done_c) state_d = (shift_q == ADDR_MATCH) ? ACK_A : IGNORE;
                ACK_A:   state_d = BYTE1;
                BYTE1:   if (byte_done_c) state_d = reg_ok_c ? ACK_1 : IGNORE;
                ACK_1:   state_d = BYTE2;
                BYTE2:   if (byte_done_c) state_d = ACK_2;
                ACK_2:   state_d = IGNORE;
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath and outputs: bit shifting, ACK drive, write commit
    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        reg_addr_d = reg_addr_q;
        data_hi_d  = data_hi_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        regs_d     = regs_q;
        oe_d       = (state_d == ACK_A) || (state_d == ACK_1) || (state_d == ACK_2);

        if (start_c) begin
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (stop_c) begin
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (scl_rise_c && shifting_c && !byte_done_c) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + BIT_CNT_W'(1);
        end else if (scl_fall_c && (state_d != state_q)) begin
            cnt_d = '0;
        end

        if ((state_q == BYTE1) && (state_d == ACK_1)) begin
            reg_addr_d = shift_q[7:1];
            data_hi_d  = shift_q[0];
        end

        // Commit coincides with the SCL fall that raises the final ACK
        if ((state_q == BYTE2) && (state_d == ACK_2)) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = reg_addr_q;
            wr_data_d  = {data_hi_q, shift_q};
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (reg_addr_q == REG_ADDR_W'(RESET_REG)) begin
                    regs_d[i] = reg_default(i);
                end else if (reg_addr_q == REG_ADDR_W'(i)) begin
                    regs_d[i] = {data_hi_q, shift_q};
                end
            end
        end
    end

    // Datapath flops; SDA release is immediate on reset assertion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            reg_addr_q <= '0;
            data_hi_q  <= 1'b0;
            oe_q       <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= reg_default(i);
        end else begin
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            reg_addr_q <= reg_addr_d;
            data_hi_q  <= data_hi_d;
            oe_q       <= oe_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            regs_q     <= regs_d;
        end
    end

    // Combinational register file read port
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == RD_ADDR_W'(i)) rd_data = regs_q[i];
        end
    end

    assign i2c_sdat_oe = oe_q;
    assign wr_valid    = wr_valid_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Self-checking bench: bit-banged I2C master against a frame-level reference model.
`timescale 1ns/1ps
module tb_i2c_codec_responder;

    localparam int H = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       i2c_sdat_oe, wr_valid, busy;
    logic [6:0] wr_addr;
    logic [8:0] wr_data, rd_data;
    logic [3:0] rd_addr = 4'd0;

    int n_tests = 0;
    int n_fail = 0;
    int wr_pulses = 0;
    int oe_data_hits = 0;

    logic [8:0] dflt [16] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A,
                              9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
    logic [8:0] mdl [16];

    assign sda_line = sda_m & ~i2c_sdat_oe;

    always #5 clk = ~clk;

    i2c_codec_responder dut (
        .clk         (clk),
        .reset       (reset),
        .i2c_sclk    (scl_m),
        .i2c_sdat_in (sda_line),
        .i2c_sdat_oe (i2c_sdat_oe),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy)
    );

    // Counts high cycles of wr_valid, so a stretched pulse shows up as an extra write
    always @(negedge clk) if (wr_valid === 1'b1) wr_pulses++;

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [3:0] exp_acks(input logic [7:0] bs [4], input int n);
        logic [3:0] r = 4'b0;
        if (n >= 1 && bs[0] == 8'h34) r[0] = 1'b1;
        if (n >= 2 && r[0] && (bs[1] >> 1) < 16) r[1] = 1'b1;
        if (n >= 3 && r[1]) r[2] = 1'b1;
        return r;
    endfunction

    function automatic void model_write(input int addr, input logic [8:0] data);
        if (addr == 15) for (int i = 0; i < 16; i++) mdl[i] = dflt[i];
        else mdl[addr] = data;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mdl[i] = dflt[i];
    endfunction

    // ---------------- bus primitives ----------------
    task automatic ncyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; ncyc(H);
        scl_m = 1'b1; ncyc(H);
        sda_m = 1'b0; ncyc(H);
        scl_m = 1'b0; ncyc(2);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; ncyc(H);
        scl_m = 1'b1; ncyc(H);
        sda_m = 1'b1; ncyc(H);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; ncyc(H);
            scl_m = 1'b1; ncyc(H / 2);
            if (i2c_sdat_oe) oe_data_hits++;
            ncyc(H / 2);
            scl_m = 1'b0; ncyc(2);
        end
    endtask

    task automatic ack_phase(output logic ack);
        sda_m = 1'b1; ncyc(H);
        scl_m = 1'b1; ncyc(H / 2);
        ack = i2c_sdat_oe;
        ncyc(H / 2);
        scl_m = 1'b0; ncyc(2);
    endtask

    task automatic xfer(input logic [7:0] bs [4], input int n, output logic [3:0] acks);
        logic a;
        acks = 4'b0;
        i2c_start();
        for (int i = 0; i < n; i++) begin
            send_bits(bs[i]);
            ack_phase(a);
            acks[i] = a;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        ncyc(4);
        n_tests++;
        if ({i2c_sdat_oe, wr_valid, busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: oe/wr_valid/busy=%b required 000", {i2c_sdat_oe, wr_valid, busy});
        end
        n_tests++;
        if (wr_addr !== 7'd0 || wr_data !== 9'd0) begin
            n_fail++; $display("FAIL reset_wr: wr_addr=%h wr_data=%h required 0 0", wr_addr, wr_data);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i); #1;
            n_tests++;
            if (rd_data !== dflt[i]) begin
                n_fail++; $display("FAIL reset_reg%0d: got %h required %h", i, rd_data, dflt[i]);
            end
        end
        ncyc(1);
        reset = 1'b1;
        model_reset();
        ncyc(4);
    endtask

    task automatic test_write_basic();
        logic [7:0] bs [4] = '{8'h34, 8'h0C, 8'h00, 8'h00};
        logic [3:0] acks;
        int p0 = wr_pulses;
        xfer(bs, 3, acks);
        n_tests++;
        if (acks !== 4'b0111) begin n_fail++; $display("FAIL basic_acks: got %b required 0111", acks); end
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_mid: got %b required 1", busy); end
        i2c_stop(); ncyc(4);
        model_write(6, 9'h000);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b required 0", busy); end
        n_tests++;
        if (wr_pulses - p0 != 1) begin n_fail++; $display("FAIL basic_pulses: got %0d required 1", wr_pulses - p0); end
        n_tests++;
        if (wr_addr !== 7'd6 || wr_data !== 9'h000) begin
            n_fail++; $display("FAIL basic_wr: addr=%0d data=%h required 6 000", wr_addr, wr_data);
        end
        rd_addr = 4'd6; #1;
        n_tests++;
        if (rd_data !== mdl[6]) begin n_fail++; $display("FAIL basic_rd6: got %h required %h", rd_data, mdl[6]); end
    endtask

    task automatic test_wrong_addr();
        logic [7:0] bs [4] = '{8'h36, 8'h0C, 8'h55, 8'h00};
        logic [3:0] acks;
        int p0 = wr_pulses;
        int h0 = oe_data_hits;
        xfer(bs, 3, acks);
        n_tests++;
        if (acks !== 4'b0000) begin n_fail++; $display("FAIL wrong_addr_acks: got %b required 0000", acks); end
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL wrong_addr_busy_mid: got %b required 1", busy); end
        i2c_stop(); ncyc(4);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_busy_end: got %b required 0", busy); end
        n_tests++;
        if (wr_pulses != p0) begin n_fail++; $display("FAIL wrong_addr_pulses: got %0d required 0", wr_pulses - p0); end
        n_tests++;
        if (oe_data_hits != h0) begin n_fail++; $display("FAIL wrong_addr_sda: oe during data %0d times required 0", oe_data_hits - h0); end
    endtask

    task automatic test_reset_reg();
        logic [7:0] b1 [4] = '{8'h34, 8'h00, 8'h17, 8'h00};
        logic [7:0] b2 [4] = '{8'h34, 8'h1E, 8'h00, 8'h00};
        logic [3:0] acks;
        int p0;
        xfer(b1, 3, acks); i2c_stop(); ncyc(4);
        model_write(0, 9'h017);
        rd_addr = 4'd0; #1;
        n_tests++;
        if (rd_data !== mdl[0]) begin n_fail++; $display("FAIL rreg_r0_set: got %h required %h", rd_data, mdl[0]); end
        p0 = wr_pulses;
        xfer(b2, 3, acks); i2c_stop(); ncyc(4);
        model_write(15, 9'h000);
        n_tests++;
        if (wr_pulses - p0 != 1 || wr_addr !== 7'd15) begin
            n_fail++; $display("FAIL rreg_pulse: pulses=%0d addr=%0d required 1 15", wr_pulses - p0, wr_addr);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i); #1;
            n_tests++;
            if (rd_data !== mdl[i]) begin n_fail++; $display("FAIL rreg_reg%0d: got %h required %h", i, rd_data, mdl[i]); end
        end
    endtask

    task automatic test_abort_restart();
        logic [7:0] bs [4] = '{8'h34, 8'h08, 8'h1F, 8'h00};
        logic [3:0] acks;
        int p0 = wr_pulses;
        xfer(bs, 2, acks); i2c_stop(); ncyc(4);
        n_tests++;
        if (acks !== 4'b0011 || wr_pulses != p0) begin
            n_fail++; $display("FAIL abort_stop: acks=%b pulses=%0d required 0011 0", acks, wr_pulses - p0);
        end
        xfer(bs, 2, acks);
        xfer(bs, 3, acks);
        i2c_stop(); ncyc(4);
        model_write(4, 9'h01F);
        n_tests++;
        if (acks !== 4'b0111 || wr_pulses - p0 != 1) begin
            n_fail++; $display("FAIL abort_rstart: acks=%b pulses=%0d required 0111 1", acks, wr_pulses - p0);
        end
        rd_addr = 4'd4; #1;
        n_tests++;
        if (rd_data !== mdl[4]) begin n_fail++; $display("FAIL abort_r4: got %h required %h", rd_data, mdl[4]); end
    endtask

    task automatic test_nack();
        logic [7:0] b1 [4] = '{8'h34, 8'h40, 8'h12, 8'h00};
        logic [7:0] b2 [4] = '{8'h34, 8'h0A, 8'h33, 8'h77};
        logic [3:0] acks;
        int p0 = wr_pulses;
        xfer(b1, 3, acks); i2c_stop(); ncyc(4);
        n_tests++;
        if (acks !== 4'b0001 || wr_pulses != p0) begin
            n_fail++; $display("FAIL nack_reg32: acks=%b pulses=%0d required 0001 0", acks, wr_pulses - p0);
        end
        xfer(b2, 4, acks); i2c_stop(); ncyc(4);
        model_write(5, 9'h033);
        n_tests++;
        if (acks !== 4'b0111 || wr_pulses - p0 != 1) begin
            n_fail++; $display("FAIL nack_extra: acks=%b pulses=%0d required 0111 1", acks, wr_pulses - p0);
        end
        rd_addr = 4'd5; #1;
        n_tests++;
        if (rd_data !== mdl[5]) begin n_fail++; $display("FAIL nack_r5: got %h required %h", rd_data, mdl[5]); end
    endtask

    task automatic test_random();
        logic [7:0] bs [4];
        logic [3:0] acks, ea;
        int n, p0, h0;
        h0 = oe_data_hits;
        for (int t = 0; t < 24; t++) begin
            n = $urandom_range(1, 4);
            bs[0] = ($urandom_range(0, 3) != 0) ? 8'h34 : 8'($urandom);
            bs[1] = {7'($urandom_range(0, 17)), 1'($urandom)};
            bs[2] = 8'($urandom);
            bs[3] = 8'($urandom);
            ea = exp_acks(bs, n);
            p0 = wr_pulses;
            xfer(bs, n, acks); i2c_stop(); ncyc(4);
            n_tests++;
            if (acks !== ea) begin n_fail++; $display("FAIL rand%0d_acks: got %b required %b", t, acks, ea); end
            if (ea[2]) model_write(int'(bs[1][7:1]), {bs[1][0], bs[2]});
            n_tests++;
            if (wr_pulses - p0 != int'(ea[2])) begin
                n_fail++; $display("FAIL rand%0d_pulses: got %0d required %0d", t, wr_pulses - p0, ea[2]);
            end
            if (ea[2]) begin
                n_tests++;
                if (wr_addr !== bs[1][7:1] || wr_data !== {bs[1][0], bs[2]}) begin
                    n_fail++; $display("FAIL rand%0d_wr: addr=%0d data=%h required %0d %h", t, wr_addr, wr_data, bs[1][7:1], {bs[1][0], bs[2]});
                end
            end
        end
        n_tests++;
        if (oe_data_hits != h0) begin n_fail++; $display("FAIL rand_sda: oe during data %0d times required 0", oe_data_hits - h0); end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i); #1;
            n_tests++;
            if (rd_data !== mdl[i]) begin n_fail++; $display("FAIL rand_reg%0d: got %h required %h", i, rd_data, mdl[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b1 [4] = '{8'h34, 8'h00, 8'h17, 8'h00};
        logic [3:0] acks;
        logic a;
        int p0, waited;
        xfer(b1, 3, acks); i2c_stop(); ncyc(4);
        i2c_start();
        send_bits(8'h34); ack_phase(a);
        send_bits(8'h08);
        p0 = wr_pulses;
        waited = 0;
        while (i2c_sdat_oe !== 1'b1 && waited < 20) begin ncyc(1); waited++; end
        n_tests++;
        if (i2c_sdat_oe !== 1'b1) begin n_fail++; $display("FAIL rmid_ack1: oe=%b required 1", i2c_sdat_oe); end
        reset = 1'b0;
        #1;
        n_tests++;
        if (i2c_sdat_oe !== 1'b0) begin n_fail++; $display("FAIL rmid_release: oe=%b required 0", i2c_sdat_oe); end
        sda_m = 1'b1; ncyc(2);
        scl_m = 1'b1; ncyc(2);
        model_reset();
        n_tests++;
        if (wr_pulses != p0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rmid_state: pulses=%0d busy=%b required 0 0", wr_pulses - p0, busy);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i); #1;
            n_tests++;
            if (rd_data !== mdl[i]) begin n_fail++; $display("FAIL rmid_reg%0d: got %h required %h", i, rd_data, mdl[i]); end
        end
        ncyc(1);
        reset = 1'b1;
        ncyc(4);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_basic();
        test_wrong_addr();
        test_reset_reg();
        test_abort_restart();
        test_nack();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
